// File: rtl/regbank_mp.sv
// Multi-port register bank with two write ports (memory port wins collisions), optional write-to-read bypass and zero register, and a per-register load scoreboard.
// Latency: write 1 edge to storage, 0 cycles on read via bypass; busy visible the cycle after issue. No backpressure: the caller stalls on RBUSY.
module regbank_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     RADDR,
    output logic [NUM_RD*DATA_WIDTH-1:0]     RDATA,
    output logic [NUM_RD-1:0]                RBUSY,
    input  logic                             WE_A,
    input  logic [ADDR_WIDTH-1:0]            WADDR_A,
    input  logic [DATA_WIDTH-1:0]            WDATA_A,
    input  logic                             WE_M,
    input  logic [ADDR_WIDTH-1:0]            WADDR_M,
    input  logic [DATA_WIDTH-1:0]            WDATA_M,
    input  logic                             LD_ISSUE,
    input  logic [ADDR_WIDTH-1:0]            LD_RD,
    output logic [ADDR_WIDTH:0]              BUSY_CNT
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    // An address is usable when it is inside the bank and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q;
    logic [ADDR_WIDTH:0]   busy_cnt_d;

    logic we_a_ok, we_m_ok, ld_ok;

    assign we_a_ok = WE_A && addr_ok(WADDR_A);
    assign we_m_ok = WE_M && addr_ok(WADDR_M);
    assign ld_ok   = LD_ISSUE && addr_ok(LD_RD);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we_a_ok) regs_d[WADDR_A] = WDATA_A;
        // Memory port applied last so it wins a same-address collision.
        if (we_m_ok) regs_d[WADDR_M] = WDATA_M;
        if (we_m_ok) busy_d[WADDR_M] = 1'b0;
        if (ld_ok)   busy_d[LD_RD]   = 1'b1;
        busy_cnt_d = '0;
        for (int j = 0; j < DEPTH; j++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[j]};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign BUSY_CNT = busy_cnt_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  ok, byp_en, hit_m, hit_a, hit_ld;
        logic [DATA_WIDTH-1:0] stored;

        assign ra     = RADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign ok     = addr_ok(ra);
        // Forwarding is gated off while reset is held so outputs read as reset state.
        assign byp_en = (BYPASS != 0) && !RST && ok;
        assign hit_m  = byp_en && WE_M && (WADDR_M == ra);
        assign hit_a  = byp_en && WE_A && (WADDR_A == ra);
        assign hit_ld = LD_ISSUE && (LD_RD == ra);
        assign stored = ok ? regs_q[ra] : '0;

        assign RDATA[g*DATA_WIDTH +: DATA_WIDTH] = hit_m ? WDATA_M :
                                                   hit_a ? WDATA_A : stored;
        assign RBUSY[g] = ok && busy_q[ra] && !(hit_m && !hit_ld);
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: a bypassing 3-port instance and a non-bypassing 4-port instance.
module tb_regbank_mp;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Instance b: BYPASS=1, NUM_RD=3
    logic [14:0] b_raddr;
    logic [95:0] b_rdata;
    logic [2:0]  b_rbusy;
    logic        b_we_a, b_we_m, b_ld;
    logic [4:0]  b_waddr_a, b_waddr_m, b_ld_rd;
    logic [31:0] b_wdata_a, b_wdata_m;
    logic [5:0]  b_cnt;

    // Instance c: BYPASS=0, NUM_RD=4
    logic [19:0]  c_raddr;
    logic [127:0] c_rdata;
    logic [3:0]   c_rbusy;
    logic         c_we_a, c_we_m, c_ld;
    logic [4:0]   c_waddr_a, c_waddr_m, c_ld_rd;
    logic [31:0]  c_wdata_a, c_wdata_m;
    logic [5:0]   c_cnt;

    regbank_mp #(.NUM_RD(3), .BYPASS(1), .ZERO_REG(1)) u_b (
        .CLK(CLK), .RST(RST), .RADDR(b_raddr), .RDATA(b_rdata), .RBUSY(b_rbusy),
        .WE_A(b_we_a), .WADDR_A(b_waddr_a), .WDATA_A(b_wdata_a),
        .WE_M(b_we_m), .WADDR_M(b_waddr_m), .WDATA_M(b_wdata_m),
        .LD_ISSUE(b_ld), .LD_RD(b_ld_rd), .BUSY_CNT(b_cnt)
    );

    regbank_mp #(.NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) u_c (
        .CLK(CLK), .RST(RST), .RADDR(c_raddr), .RDATA(c_rdata), .RBUSY(c_rbusy),
        .WE_A(c_we_a), .WADDR_A(c_waddr_a), .WDATA_A(c_wdata_a),
        .WE_M(c_we_m), .WADDR_M(c_waddr_m), .WDATA_M(c_wdata_m),
        .LD_ISSUE(c_ld), .LD_RD(c_ld_rd), .BUSY_CNT(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic b_idle();
        b_we_a = 0; b_we_m = 0; b_ld = 0;
    endtask

    task automatic c_idle();
        c_we_a = 0; c_we_m = 0; c_ld = 0;
    endtask

    initial begin
        b_raddr = '0; b_waddr_a = '0; b_waddr_m = '0; b_ld_rd = '0;
        b_wdata_a = '0; b_wdata_m = '0; b_idle();
        c_raddr = '0; c_waddr_a = '0; c_waddr_m = '0; c_ld_rd = '0;
        c_wdata_a = '0; c_wdata_m = '0; c_idle();
        #1;
        check("reset_cnt", {26'd0, b_cnt}, 32'd0);
        check("reset_rdata0", b_rdata[31:0], 32'd0);
        check("reset_rbusy", {29'd0, b_rbusy}, 32'd0);
        tick(); tick();
        RST = 1'b0;
        #1;

        // Collision on x5: memory port data wins, also on the bypass path.
        b_we_a = 1; b_waddr_a = 5; b_wdata_a = 32'hAAAA0000;
        b_we_m = 1; b_waddr_m = 5; b_wdata_m = 32'h5555FFFF;
        b_raddr[4:0] = 5;
        #1;
        check("coll_bypass", b_rdata[31:0], 32'h5555FFFF);
        tick(); b_idle(); #1;
        check("coll_stored", b_rdata[31:0], 32'h5555FFFF);

        // Zero register: writes and load issue to x0 have no effect.
        b_we_a = 1; b_waddr_a = 0; b_wdata_a = 32'hDEADBEEF;
        b_we_m = 1; b_waddr_m = 0; b_wdata_m = 32'hDEADBEEF;
        b_ld = 1; b_ld_rd = 0;
        b_raddr[9:5] = 0;
        #1;
        check("zero_bypass", b_rdata[63:32], 32'd0);
        check("zero_rbusy_now", {31'd0, b_rbusy[1]}, 32'd0);
        tick(); b_idle(); #1;
        check("zero_stored", b_rdata[63:32], 32'd0);
        check("zero_rbusy", {31'd0, b_rbusy[1]}, 32'd0);
        check("zero_cnt", {26'd0, b_cnt}, 32'd0);

        // Scoreboard on x7 through port 2.
        b_raddr[14:10] = 7;
        b_ld = 1; b_ld_rd = 7;
        #1;
        check("sb_busy_before_edge", {31'd0, b_rbusy[2]}, 32'd0);
        tick(); b_idle(); #1;
        check("sb_busy", {31'd0, b_rbusy[2]}, 32'd1);
        check("sb_cnt1", {26'd0, b_cnt}, 32'd1);
        tick(); tick();
        b_we_m = 1; b_waddr_m = 7; b_wdata_m = 32'h12345678;
        #1;
        check("sb_mask", {31'd0, b_rbusy[2]}, 32'd0);
        check("sb_fwd", b_rdata[95:64], 32'h12345678);
        check("sb_cnt_hold", {26'd0, b_cnt}, 32'd1);
        tick(); b_idle(); #1;
        check("sb_cnt0", {26'd0, b_cnt}, 32'd0);
        check("sb_clear", {31'd0, b_rbusy[2]}, 32'd0);
        check("sb_data", b_rdata[95:64], 32'h12345678);

        // Set beats clear on x9.
        b_raddr[4:0] = 9;
        b_ld = 1; b_ld_rd = 9;
        tick(); b_idle(); #1;
        check("sbc_pre_cnt", {26'd0, b_cnt}, 32'd1);
        b_we_m = 1; b_waddr_m = 9; b_wdata_m = 32'hCAFEF00D;
        b_ld = 1; b_ld_rd = 9;
        #1;
        check("sbc_nomask", {31'd0, b_rbusy[0]}, 32'd1);
        check("sbc_fwd", b_rdata[31:0], 32'hCAFEF00D);
        tick(); b_idle(); #1;
        check("sbc_busy", {31'd0, b_rbusy[0]}, 32'd1);
        check("sbc_cnt", {26'd0, b_cnt}, 32'd1);
        check("sbc_data", b_rdata[31:0], 32'hCAFEF00D);

        // ALU writeback does not clear busy.
        b_we_a = 1; b_waddr_a = 9; b_wdata_a = 32'h00000011;
        #1;
        check("alu_busy_now", {31'd0, b_rbusy[0]}, 32'd1);
        check("alu_fwd", b_rdata[31:0], 32'h00000011);
        tick(); b_idle(); #1;
        check("alu_cnt", {26'd0, b_cnt}, 32'd1);
        check("alu_data", b_rdata[31:0], 32'h00000011);

        // Mid-operation reset with pending writes and a load issue.
        b_we_a = 1; b_waddr_a = 9; b_wdata_a = 32'h00000077;
        b_ld = 1; b_ld_rd = 10;
        RST = 1'b1;
        #1;
        check("rst_rdata", b_rdata[31:0], 32'd0);
        check("rst_rbusy", {29'd0, b_rbusy}, 32'd0);
        check("rst_cnt", {26'd0, b_cnt}, 32'd0);
        check("rst_x5", b_rdata[31:0] | {27'd0, b_raddr[4:0]} ^ 32'd9, 32'd0);
        tick();
        RST = 1'b0; b_idle();
        #1;
        check("post_rst_x9", b_rdata[31:0], 32'd0);
        check("post_rst_cnt", {26'd0, b_cnt}, 32'd0);
        b_raddr[9:5] = 5;
        #1;
        check("post_rst_x5", b_rdata[63:32], 32'd0);
        b_we_a = 1; b_waddr_a = 4; b_wdata_a = 32'h0000ABCD;
        b_raddr[14:10] = 4;
        tick(); b_idle(); #1;
        check("first_write", b_rdata[95:64], 32'h0000ABCD);

        // Non-bypassing instance.
        c_we_a = 1; c_waddr_a = 3; c_wdata_a = 32'h00000011;
        c_raddr[4:0] = 3;
        tick(); c_idle(); #1;
        c_we_a = 1; c_waddr_a = 3; c_wdata_a = 32'h00000042;
        #1;
        check("nb_old", c_rdata[31:0], 32'h00000011);
        tick(); c_idle(); #1;
        check("nb_new", c_rdata[31:0], 32'h00000042);

        c_we_a = 1; c_waddr_a = 1; c_wdata_a = 32'h10101010;
        c_we_m = 1; c_waddr_m = 2; c_wdata_m = 32'h20202020;
        tick(); c_idle();
        c_we_a = 1; c_waddr_a = 6; c_wdata_a = 32'h60606060;
        tick(); c_idle();
        c_raddr = {5'd6, 5'd2, 5'd1, 5'd3};
        #1;
        check("nb_p0", c_rdata[31:0],   32'h00000042);
        check("nb_p1", c_rdata[63:32],  32'h10101010);
        check("nb_p2", c_rdata[95:64],  32'h20202020);
        check("nb_p3", c_rdata[127:96], 32'h60606060);

        c_ld = 1; c_ld_rd = 6;
        tick(); c_idle(); #1;
        check("nb_busy", {31'd0, c_rbusy[3]}, 32'd1);
        c_we_m = 1; c_waddr_m = 6; c_wdata_m = 32'h66666666;
        #1;
        check("nb_nomask", {31'd0, c_rbusy[3]}, 32'd1);
        check("nb_nofwd", c_rdata[127:96], 32'h60606060);
        tick(); c_idle(); #1;
        check("nb_clear", {31'd0, c_rbusy[3]}, 32'd0);
        check("nb_ldata", c_rdata[127:96], 32'h66666666);
        check("nb_cnt", {26'd0, c_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regbank_mp.md
# regbank_mp

Parametrised multi-port register bank for the RISC-V core: configurable depth/width, NUM_RD combinational read ports, two write ports (ALU writeback and memory/load writeback) with fixed collision priority, optional same-cycle write-to-read bypass, optional hard-wired zero register, and a per-register load scoreboard that flags operands still waiting on an outstanding load. Sits between decode (read ports, scoreboard queries) and the writeback stage (both write ports).

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register width
- DEPTH, 32, number of registers (must be ≤ 2**ADDR_WIDTH)
- NUM_RD, 3, number of read ports
- BYPASS, 1, 1 = read data forwards same-cycle write data
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/scoreboard

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- RADDR  in  NUM_RD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- RDATA  out  NUM_RD*DATA_WIDTH  read data, same packing
- RBUSY  out  NUM_RD  port i's register has an outstanding load
- WE_A, WADDR_A, WDATA_A  in  1/ADDR_WIDTH/DATA_WIDTH  ALU writeback port
- WE_M, WADDR_M, WDATA_M  in  1/ADDR_WIDTH/DATA_WIDTH  memory writeback port
- LD_ISSUE  in  1  load issued this cycle
- LD_RD  in  ADDR_WIDTH  destination register of issued load
- BUSY_CNT  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- Storage: DEPTH x DATA_WIDTH flops, plus DEPTH busy bits. No file preload; contents defined only by reset and writes.
- Writes: each port with WE high writes its data at the rising edge. WADDR ≥ DEPTH: write ignored.
- Collision: WE_A and WE_M to same address in one cycle → WDATA_M is stored; WDATA_A dropped.
- Reads: RDATA[i] = regfile[RADDR[i]], combinational. RADDR ≥ DEPTH → 0.
- Bypass (BYPASS=1): if WE_M && WADDR_M==RADDR[i] → WDATA_M; else if WE_A && WADDR_A==RADDR[i] → WDATA_A; else stored value. BYPASS=0: stored value only (new data visible the cycle after the edge).
- ZERO_REG=1: address 0 always reads 0 (bypass included), writes to 0 discarded, LD_ISSUE to 0 does not set busy, RBUSY for address 0 is 0.
- Scoreboard: LD_ISSUE sets busy[LD_RD]; WE_M clears busy[WADDR_M]. Same cycle, same address: set wins (back-to-back load to same rd). WE_A does not affect busy bits.
- RBUSY[i] = busy[RADDR[i]]; with BYPASS=1, a WE_M to RADDR[i] in the current cycle masks RBUSY[i] to 0 (data forwarded), unless LD_ISSUE targets the same register that cycle. BYPASS=0: RBUSY reflects registered busy only.
- BUSY_CNT: registered population count of busy bits, updated at the same edge as the bits.

## Timing
- Reset (RST high, asynchronous): all registers 0, all busy bits 0, BUSY_CNT=0; RDATA therefore 0 and RBUSY 0 (except bypassed paths, which are gated off during reset: RDATA=0, RBUSY=0 while RST high).
- Write latency: 1 edge to storage; 0 cycles to read with BYPASS=1.
- Scoreboard latency: busy visible on RBUSY the cycle after LD_ISSUE edge; cleared busy visible after WE_M edge (or same cycle via bypass mask).
- RST asserted mid-operation: pending writes and issue in that cycle discarded; state returns to reset values immediately; first write accepted on first rising edge after RST deasserts.
- No handshake/backpressure; caller must stall on RBUSY.

## Test plan
- Reset: drive RST=1 with prior non-zero contents → all RDATA=0, RBUSY=0, BUSY_CNT=0 without a clock edge.
- Write collision: WE_A=WE_M=1, WADDR both 5, WDATA_A=0xAAAA0000, WDATA_M=0x5555FFFF → next cycle RADDR=5 reads 0x5555FFFF; same cycle (BYPASS=1) also 0x5555FFFF.
- Zero register: write 0xDEADBEEF to x0 on both ports and LD_ISSUE LD_RD=0 → RDATA=0, RBUSY=0, BUSY_CNT=0.
- Scoreboard: LD_ISSUE to x7 → next cycle RBUSY=1, BUSY_CNT=1; two cycles later WE_M x7=0x12345678 → same cycle RBUSY=0, RDATA=0x12345678; next cycle BUSY_CNT=0.
- Set-beats-clear: WE_M x9 and LD_ISSUE x9 in same cycle → busy[9] stays 1, BUSY_CNT unchanged; x9 holds WE_M data.
- BYPASS=0 instance: write x3=0x00000042 → same cycle RDATA=old value, next cycle 0x00000042; NUM_RD=4 read all ports to distinct registers returning correct data.
